// File: rtl/instruction_server_pkg.sv
// Shared types and default constants for the instruction server.
// The optional ACK timeout is enabled by defining INSTR_SERVER_TIMEOUT_EN.
package instruction_server_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      ACK   = 2'd2,
      DRAIN = 2'd3
   } srv_state_t;

   localparam int DEF_ADDR_WIDTH     = 8;
   localparam int DEF_SYNC_STAGES    = 2;
   localparam int DEF_TIMEOUT_CYCLES = 1023;
   localparam int DEF_DATA_WIDTH     = 8;

   // Counter must be able to hold the value TIMEOUT_CYCLES itself.
   function automatic int timeout_cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

   localparam int TIMEOUT_CNT_WIDTH = $clog2(DEF_TIMEOUT_CYCLES + 1);

endpackage

// File: rtl/handshake_sync.sv
// N-stage flip-flop synchronizer with asynchronous active-high reset.
module handshake_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the asynchronous input through the synchronizer chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/instruction_server.sv
// Four-phase req/ack responder serving bytes from a loadable program store.
// Optional ACK timeout with DRAIN state: define INSTR_SERVER_TIMEOUT_EN.
module instruction_server
   import instruction_server_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] instruction_address_input,
   input  logic                  receive_signal,
   output logic [7:0]            instruction_output,
   output logic                  transmit_signal,
   input  logic                  load_enable,
   input  logic [ADDR_WIDTH-1:0] load_address,
   input  logic [7:0]            load_data,
   output logic                  load_ready,
   output logic                  busy,
   output logic                  timeout
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("instruction_server: SYNC_STAGES must be 2..4 and TIMEOUT_CYCLES >= 1");
   end

   srv_state_t state, next_state;
   logic       req_s;
   logic       fetch;
   logic       ack_set;
   logic       ack_clr;
   logic       tmo_set;
   logic [7:0] rd_data;
   logic [7:0] mem [0:(1<<ADDR_WIDTH)-1];

   handshake_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk (clk),
      .rst (rst),
      .d   (receive_signal),
      .q   (req_s)
   );

   // A pending request blocks loads so the fetch never races a write.
   assign load_ready = (state == IDLE) && !req_s;

`ifdef INSTR_SERVER_TIMEOUT_EN
   localparam int CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] ack_cnt;
`endif

   // Next-state and transition strobes.
   always_comb begin
      next_state = state;
      fetch      = 1'b0;
      ack_set    = 1'b0;
      ack_clr    = 1'b0;
      tmo_set    = 1'b0;
      case (state)
         IDLE: begin
            if (req_s) begin
               next_state = READ;
               fetch      = 1'b1;
            end else begin
               next_state = IDLE;
            end
         end
         READ: begin
            next_state = ACK;
            ack_set    = 1'b1;
         end
         ACK: begin
            if (!req_s) begin
               next_state = IDLE;
               ack_clr    = 1'b1;
`ifdef INSTR_SERVER_TIMEOUT_EN
            end else if (ack_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               next_state = DRAIN;
               ack_clr    = 1'b1;
               tmo_set    = 1'b1;
`endif
            end else begin
               next_state = ACK;
            end
         end
         DRAIN: begin
`ifdef INSTR_SERVER_TIMEOUT_EN
            if (!req_s) begin
               next_state = IDLE;
            end else begin
               next_state = DRAIN;
            end
`else
            next_state = IDLE;
`endif
         end
         default: next_state = IDLE;
      endcase
   end

   // State, acknowledge and returned-byte registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= IDLE;
         transmit_signal    <= 1'b0;
         instruction_output <= 8'h00;
         busy               <= 1'b0;
      end else begin
         state <= next_state;
         busy  <= (next_state != IDLE);
         if (ack_set) begin
            transmit_signal    <= 1'b1;
            instruction_output <= rd_data;
         end else if (ack_clr) begin
            transmit_signal <= 1'b0;
         end
      end
   end

   // Program store: contents survive reset.
   always_ff @(posedge clk) begin
      if (load_enable && load_ready) begin
         mem[load_address] <= load_data;
      end
      if (fetch) begin
         rd_data <= mem[instruction_address_input];
      end
   end

`ifdef INSTR_SERVER_TIMEOUT_EN
   // ACK dwell counter and sticky abort flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_cnt <= '0;
         timeout <= 1'b0;
      end else begin
         if (state == ACK && next_state == ACK) begin
            ack_cnt <= ack_cnt + CNT_W'(1);
         end else begin
            ack_cnt <= '0;
         end
         if (tmo_set) begin
            timeout <= 1'b1;
         end
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_server.sv
// Directed self-checking bench for instruction_server (SYNC_STAGES=2, TIMEOUT_CYCLES=15).
module tb_instruction_server;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] instruction_address_input;
   logic       receive_signal;
   logic [7:0] instruction_output;
   logic       transmit_signal;
   logic       load_enable;
   logic [7:0] load_address;
   logic [7:0] load_data;
   logic       load_ready;
   logic       busy;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instruction_server #(
      .ADDR_WIDTH     (8),
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (15)
   ) dut (
      .clk                       (clk),
      .rst                       (rst),
      .instruction_address_input (instruction_address_input),
      .receive_signal            (receive_signal),
      .instruction_output        (instruction_output),
      .transmit_signal           (transmit_signal),
      .load_enable               (load_enable),
      .load_address              (load_address),
      .load_data                 (load_data),
      .load_ready                (load_ready),
      .busy                      (busy),
      .timeout                   (timeout)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input logic [7:0] a, input logic [7:0] d);
      check("load_ready_idle", {7'd0, load_ready}, 8'h01);
      load_enable  = 1'b1;
      load_address = a;
      load_data    = d;
      tick(1);
      load_enable  = 1'b0;
   endtask

   // Raise request; ack must appear exactly SYNC_STAGES+2 edges later.
   task automatic start_req(input logic [7:0] a, input logic [7:0] exp, input string tag);
      instruction_address_input = a;
      receive_signal = 1'b1;
      tick(3);
      check({tag, "_ack_early"}, {7'd0, transmit_signal}, 8'h00);
      tick(1);
      check({tag, "_ack_rise"}, {7'd0, transmit_signal}, 8'h01);
      check({tag, "_data"}, instruction_output, exp);
      check({tag, "_busy"}, {7'd0, busy}, 8'h01);
   endtask

   // Drop request; ack falls one edge after the synchronized request falls.
   task automatic end_req(input string tag);
      receive_signal = 1'b0;
      tick(2);
      check({tag, "_ack_hold"}, {7'd0, transmit_signal}, 8'h01);
      tick(1);
      check({tag, "_ack_fall"}, {7'd0, transmit_signal}, 8'h00);
      check({tag, "_idle"}, {7'd0, busy}, 8'h00);
   endtask

   initial begin
      rst = 1'b1;
      receive_signal = 1'b0;
      instruction_address_input = 8'h00;
      load_enable = 1'b0;
      load_address = 8'h00;
      load_data = 8'h00;
      tick(3);
      check("rst_ack", {7'd0, transmit_signal}, 8'h00);
      check("rst_data", instruction_output, 8'h00);
      check("rst_busy", {7'd0, busy}, 8'h00);
      check("rst_timeout", {7'd0, timeout}, 8'h00);
      rst = 1'b0;
      tick(1);

      // Basic fetch
      load(8'h10, 8'hA5);
      start_req(8'h10, 8'hA5, "f10");
      end_req("f10");

      // Back-to-back fetches
      load(8'h00, 8'h34);
      load(8'h01, 8'h12);
      start_req(8'h00, 8'h34, "f00");
      end_req("f00");
      start_req(8'h01, 8'h12, "f01");
      end_req("f01");

      // Load attempted during ACK is dropped
      load(8'h20, 8'h5A);
      start_req(8'h20, 8'h5A, "f20a");
      load_enable = 1'b1;
      load_address = 8'h20;
      load_data = 8'hFF;
      check("load_ready_ack", {7'd0, load_ready}, 8'h00);
      tick(1);
      load_enable = 1'b0;
      end_req("f20a");
      start_req(8'h20, 8'h5A, "f20b");
      end_req("f20b");

      // Async reset while in ACK, request held through release
      start_req(8'h10, 8'hA5, "r10a");
      #2;
      rst = 1'b1;
      #1;
      check("rst_ack_async", {7'd0, transmit_signal}, 8'h00);
      check("rst_data_async", instruction_output, 8'h00);
      check("rst_busy_async", {7'd0, busy}, 8'h00);
      tick(1);
      rst = 1'b0;
      start_req(8'h10, 8'hA5, "r10b");
      end_req("r10b");

      // Load in the cycle req_s first rises is dropped
      load(8'h30, 8'h11);
      instruction_address_input = 8'h30;
      receive_signal = 1'b1;
      tick(2);
      load_enable = 1'b1;
      load_address = 8'h30;
      load_data = 8'hEE;
      check("load_ready_req", {7'd0, load_ready}, 8'h00);
      tick(1);
      load_enable = 1'b0;
      tick(1);
      check("f30a_ack", {7'd0, transmit_signal}, 8'h01);
      check("f30a_data", instruction_output, 8'h11);
      end_req("f30a");
      start_req(8'h30, 8'h11, "f30b");

`ifdef INSTR_SERVER_TIMEOUT_EN
      // Request held: ack aborts after 15 ACK cycles
      tick(14);
      check("tmo_ack_hold", {7'd0, transmit_signal}, 8'h01);
      check("tmo_flag_low", {7'd0, timeout}, 8'h00);
      tick(1);
      check("tmo_ack_drop", {7'd0, transmit_signal}, 8'h00);
      check("tmo_flag", {7'd0, timeout}, 8'h01);
      check("tmo_busy", {7'd0, busy}, 8'h01);
      tick(20);
      check("tmo_drain_busy", {7'd0, busy}, 8'h01);
      receive_signal = 1'b0;
      tick(2);
      check("tmo_drain_wait", {7'd0, busy}, 8'h01);
      tick(1);
      check("tmo_idle", {7'd0, busy}, 8'h00);
      check("tmo_sticky", {7'd0, timeout}, 8'h01);
`else
      // Without timeout the ack is held indefinitely
      tick(40);
      check("hold_ack", {7'd0, transmit_signal}, 8'h01);
      check("hold_no_timeout", {7'd0, timeout}, 8'h00);
      end_req("f30b");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instruction_server.md
# instruction_server

Host-side responder for the instruction-fetch handshake: answers byte-wide fetch requests from `async_control` in a second device (or a loop-back bench) by returning bytes from a loadable 256-byte program store. Completes the four-phase req/ack protocol from the opposite end. The requester's `transmit_signal` arrives as our `receive_signal`; our `transmit_signal` is its `receive_signal`. Each 16-bit instruction is served as two consecutive byte addresses.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: byte-address width; store depth is 2**ADDR_WIDTH bytes.
- `SYNC_STAGES`, 2: flip-flop stages on `receive_signal`; legal range 2 to 4.
- `TIMEOUT_CYCLES`, 1023: maximum ack-high cycles before abort. Used only with `INSTR_SERVER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `instruction_address_input`  in  ADDR_WIDTH  byte address from the requester; bundled data.
- `receive_signal`  in  1  request from the requester; asynchronous.
- `instruction_output`  out  8  returned byte.
- `transmit_signal`  out  1  acknowledge.
- `load_enable`  in  1  program-store write strobe.
- `load_address`  in  ADDR_WIDTH  write address.
- `load_data`  in  8  write data.
- `load_ready`  out  1  high when a write is accepted this cycle.
- `busy`  out  1  high in any state other than IDLE.
- `timeout`  out  1  sticky abort flag.

## Operation
- Protocol is four-phase, bundled data. The requester holds the address stable from before request rise until it sees ack. We hold `instruction_output` stable from ack rise until the next ack rise.
- `receive_signal` passes through a SYNC_STAGES-deep synchronizer, giving `req_s`. The address bus is not synchronized.
- State machine:
  - **IDLE**: on `req_s`=1, latch the address, issue a synchronous read, go to READ.
  - **READ**: register the read byte onto `instruction_output`, set `transmit_signal`=1, go to ACK.
  - **ACK**: on `req_s`=0, clear `transmit_signal` and go to IDLE.
- Writes to the store:
  - `load_ready` = (state==IDLE) && !`req_s`.
  - A write occurs when `load_enable && load_ready`.
  - A write attempted in any other cycle is dropped silently. Request detection wins over a simultaneous load.
- Address is taken modulo store depth, so there is no out-of-range case.
- Reset (async, any state): `transmit_signal`=0, `instruction_output`=0x00, `busy`=0, `timeout`=0, state=IDLE, synchronizer cleared. Store contents are not reset.
- If `req_s` is still high after reset, a new transaction starts normally.

## Timing
- Request rise at the pin to `req_s` high: SYNC_STAGES edges.
- `req_s` high to `transmit_signal` high: 2 edges (IDLE→READ→ACK). Data is valid on the same edge as ack.
- `req_s` low to `transmit_signal` low: 1 edge.
- Minimum full transaction: 2·SYNC_STAGES+3 cycles plus requester latency.
- A store write is visible to a fetch starting the next cycle.
- `busy` is registered from state. `load_ready` is combinational from state and `req_s`.

## Configuration
- `INSTR_SERVER_TIMEOUT_EN` defined:
  - A counter runs while in ACK.
  - At TIMEOUT_CYCLES, clear `transmit_signal`, set `timeout` (cleared only by `rst`), and go to DRAIN.
  - DRAIN waits for `req_s`=0, then goes to IDLE.
- `INSTR_SERVER_TIMEOUT_EN` undefined: ACK waits indefinitely, `timeout` is tied to 0, and the DRAIN state and counter are absent.

## Structure
- `instruction_server_pkg` holds:
  - state enum `srv_state_t` (IDLE, READ, ACK, DRAIN);
  - default width constants;
  - the timeout counter width, $clog2(TIMEOUT_CYCLES+1).
- Sub-module `handshake_sync`: parameterized N-stage synchronizer with async-reset, reused for the req input.

## Test plan
- Load 0xA5 at address 0x10, then run a request with address 0x10 → `transmit_signal` rises SYNC_STAGES+2 cycles after request rise, `instruction_output`=0xA5, and ack falls 1 cycle after `req_s` falls.
- Load 0x34 at 0x00 and 0x12 at 0x01, then fetch both back-to-back → bytes 0x34 then 0x12; `busy` is low between transactions.
- Pulse `load_enable` to address 0x20 with data 0xFF while in ACK → `load_ready`=0 and the later fetch of 0x20 returns the old value.
- Assert `rst` while in ACK → `transmit_signal` goes to 0 immediately; after release with request still high, a new ack follows in SYNC_STAGES+2 cycles and store data is intact.
- With `INSTR_SERVER_TIMEOUT_EN` and TIMEOUT_CYCLES=15, hold the request high → ack drops after 15 ACK cycles, `timeout`=1, and the block stays `busy` until the request falls.
- Drive `load_enable` in the same cycle `req_s` first goes high → write dropped and the fetch completes normally.
